// File: rtl/byte_cipher_round_ctrl.sv
// Iterative 8-bit round controller: key-mix, external S-box, rotate; one round per cycle.
// Optional build macro CIPHER_FINAL_WHITEN_EN adds post-whitening with the next round key.
module byte_cipher_round_ctrl #(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [7:0] in_key,
  output logic [7:0] sbox_in,
  input  logic [7:0] sbox_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  generate
    if (ROUNDS < 1 || ROUNDS > 15) begin : g_bad_rounds
      $error("byte_cipher_round_ctrl: ROUNDS must be in 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_e;

  localparam logic [3:0] LAST_RC = 4'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [7:0] st_q, st_d;
  logic [7:0] rk_q, rk_d;
  logic [3:0] rc_q, rc_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;

  logic [3:0] rc_inc;
  logic [7:0] rk_next;
  logic [7:0] st_round;

  // Round datapath: the S-box is an external combinational LUT closed within this cycle.
  assign rc_inc   = rc_q + 4'd1;
  assign rk_next  = {rk_q[4:0], rk_q[7:5]} ^ {4'h0, rc_inc};
  assign st_round = {sbox_out[6:0], sbox_out[7]};

  assign sbox_in   = st_q ^ rk_q;
  assign out_data  = st_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  always_comb begin
    // NOTE: every _d defaults to its held value first, so no path can infer a latch.
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    rc_d        = rc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d       = in_data;
          rk_d       = in_key;
          rc_d       = 4'd0;
          state_d    = S_ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      S_ROUND: begin
        st_d = st_round;
        rk_d = rk_next;
        rc_d = rc_inc;
        if (rc_q == LAST_RC) begin
`ifdef CIPHER_FINAL_WHITEN_EN
          st_d = st_round ^ rk_next;
`endif
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // NOTE: asynchronous reset clears every flop at once; state updates use non-blocking only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      st_q        <= 8'h00;
      rk_q        <= 8'h00;
      rc_q        <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      rc_q        <= rc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_byte_cipher_round_ctrl.sv
// Self-checking bench for byte_cipher_round_ctrl at ROUNDS = 1, 2, 4 and 15, each with an S-box LUT.
// Expected values come from an arithmetic reference model of the cipher rounds.
module tb_byte_cipher_round_ctrl;

  localparam int N = 4;
  localparam int RN [N] = '{1, 2, 4, 15};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef CIPHER_FINAL_WHITEN_EN
  localparam logic [7:0] EXP_R1 = 8'hC7;
  localparam logic [7:0] EXP_R2 = 8'h39;
  localparam bit         WHITEN = 1'b1;
`else
  localparam logic [7:0] EXP_R1 = 8'hC6;
  localparam logic [7:0] EXP_R2 = 8'h33;
  localparam bit         WHITEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic [7:0] in_data   [N];
  logic [7:0] in_key    [N];
  logic [7:0] sbox_in   [N];
  logic [7:0] sbox_out  [N];
  logic       out_valid [N];
  logic       out_ready [N];
  logic [7:0] out_data  [N];
  logic       busy      [N];

  int total = 0;
  int bad   = 0;
  logic [7:0] sb_trace [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign sbox_out[g] = SBOX[sbox_in[g]];
    byte_cipher_round_ctrl #(.ROUNDS(RN[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_key   (in_key[g]),
      .sbox_in  (sbox_in[g]),
      .sbox_out (sbox_out[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .busy     (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    int v;
    v = int'(x);
    return 8'(((v << n) | (v >> (8 - n))) & 255);
  endfunction

  // Reference cipher: plain loop over rounds on byte values.
  function automatic logic [7:0] model(input int rounds, input logic [7:0] d, input logic [7:0] k);
    logic [7:0] st, rk, nk;
    st = d;
    rk = k;
    for (int r = 0; r < rounds; r++) begin
      nk = rotl(rk, 3) ^ 8'((r + 1) % 16);
      st = rotl(SBOX[st ^ rk], 1);
      if (WHITEN && r == rounds - 1) st = st ^ nk;
      rk = nk;
    end
    return st;
  endfunction

  // Called on a falling edge; returns cycles from the accept edge until out_valid is seen.
  task automatic wait_out(input int g, output int lat);
    lat = 1;
    while (!out_valid[g] && lat < 100) begin
      sb_trace.push_back(sbox_in[g]);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_txn(input int g, input logic [7:0] d, input logic [7:0] k,
                        output logic [7:0] res, output int lat);
    int n = 0;
    sb_trace.delete();
    while (!in_ready[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    in_data[g]  = d;
    in_key[g]   = k;
    in_valid[g] = 1'b1;
    @(negedge clk);
    in_valid[g] = 1'b0;
    wait_out(g, lat);
    res = out_data[g];
    out_ready[g] = 1'b1;
    @(negedge clk);
    out_ready[g] = 1'b0;
  endtask

  task automatic b2b(input int g);
    logic [7:0] exp_q [$];
    int accepts = 0;
    int outs    = 0;
    int last    = -1;
    int cyc     = 0;
    bit new_pending = 1'b0;
    in_data[g]   = 8'($urandom);
    in_key[g]    = 8'($urandom);
    in_valid[g]  = 1'b1;
    out_ready[g] = 1'b1;
    while (outs < 8 && cyc < 400) begin
      if (new_pending) begin
        new_pending = 1'b0;
        if (accepts == 8) in_valid[g] = 1'b0;
        else begin
          in_data[g] = 8'($urandom);
          in_key[g]  = 8'($urandom);
        end
      end
      if (in_valid[g] && in_ready[g]) begin
        exp_q.push_back(model(RN[g], in_data[g], in_key[g]));
        if (last >= 0) check($sformatf("b2b_spacing_r%0d", RN[g]), cyc - last, RN[g] + 2);
        last = cyc;
        accepts++;
        new_pending = 1'b1;
      end
      if (out_valid[g]) begin
        if (exp_q.size() == 0) check($sformatf("b2b_spurious_r%0d", RN[g]), 1, 0);
        else check($sformatf("b2b_data_r%0d", RN[g]), out_data[g], exp_q.pop_front());
        outs++;
      end
      @(negedge clk);
      cyc++;
    end
    check($sformatf("b2b_count_r%0d", RN[g]), outs, 8);
    in_valid[g]  = 1'b0;
    out_ready[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] res, exp_v, d, k;
    int lat;
    bit stable, seen;

    rst_n = 1'b0;
    for (int g = 0; g < N; g++) begin
      in_valid[g]  = 1'b0;
      in_data[g]   = 8'h00;
      in_key[g]    = 8'h00;
      out_ready[g] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_in_ready%0d", g),  in_ready[g],  1);
      check($sformatf("rst_out_valid%0d", g), out_valid[g], 0);
      check($sformatf("rst_out_data%0d", g),  out_data[g],  0);
      check($sformatf("rst_busy%0d", g),      busy[g],      0);
      check($sformatf("rst_sbox_in%0d", g),   sbox_in[g],   0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(0, 8'h00, 8'h00, res, lat);
    check("r1_latency", lat, 2);
    check("r1_data", res, EXP_R1);
    check("r1_idle_ready", in_ready[0], 1);
    check("r1_idle_valid", out_valid[0], 0);

    do_txn(1, 8'h01, 8'h00, res, lat);
    check("r2_latency", lat, 3);
    check("r2_trace_len", sb_trace.size(), 2);
    if (sb_trace.size() >= 2) begin
      check("r2_sbox_in_round0", sb_trace[0], 8'h01);
      check("r2_sbox_in_round1", sb_trace[1], 8'hF9);
    end
    check("r2_data", res, EXP_R2);

    // Backpressure on ROUNDS=4 with a competing request waiting.
    in_data[2]  = 8'h3C;
    in_key[2]   = 8'h96;
    in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    wait_out(2, lat);
    exp_v = model(4, 8'h3C, 8'h96);
    check("bp_latency", lat, 5);
    check("bp_data", out_data[2], exp_v);
    in_data[2]  = 8'h55;
    in_key[2]   = 8'hA3;
    in_valid[2] = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[2] !== 1'b1 || out_data[2] !== exp_v || in_ready[2] !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;
    check("bp_hs_in_ready", in_ready[2], 1);
    check("bp_hs_out_valid", out_valid[2], 0);
    check("bp_hs_busy", busy[2], 0);
    @(negedge clk);
    in_valid[2] = 1'b0;
    check("bp_accept_next_busy", busy[2], 1);
    sb_trace.delete();
    wait_out(2, lat);
    check("bp_second_latency", lat, 5);
    check("bp_second_data", out_data[2], model(4, 8'h55, 8'hA3));
    out_ready[2] = 1'b1;
    @(negedge clk);
    out_ready[2] = 1'b0;

    // Asynchronous reset during the second ROUND cycle.
    in_data[2]  = 8'hE1;
    in_key[2]   = 8'h5A;
    in_valid[2] = 1'b1;
    @(negedge clk);
    in_valid[2] = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", in_ready[2], 1);
    check("rst_mid_busy", busy[2], 0);
    check("rst_mid_out_valid", out_valid[2], 0);
    check("rst_mid_sbox_in", sbox_in[2], 0);
    check("rst_mid_out_data", out_data[2], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid[2]) seen = 1'b1;
    end
    check("rst_no_output", seen, 0);

    d = 8'($urandom);
    k = 8'($urandom);
    do_txn(3, d, k, res, lat);
    check("r15_latency", lat, 16);
    check("r15_data", res, model(15, d, k));

    for (int g = 0; g < N; g++) b2b(g);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_cipher_round_ctrl.md
# byte_cipher_round_ctrl

Iterative round controller for the 8-bit cryptosystem. It accepts one plaintext byte and one key byte per transaction over a valid/ready handshake, then runs ROUNDS key-mix/substitute/rotate rounds. Each round uses the external combinational S-box LUT, one round per cycle. It sits directly upstream of the S-box LUT, which it drives and consumes in the same cycle, and delivers the ciphertext byte downstream over a second valid/ready handshake.

## Interface
- ROUNDS, 4, number of rounds; legal 1..15; outside that range is an elaboration error.
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream byte+key available
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  8  plaintext byte
- in_key  in  8  key byte, sampled with in_data
- sbox_in  out  8  S-box LUT address, combinational = st ^ rk
- sbox_out  in  8  S-box LUT result, same-cycle combinational
- out_valid  out  1  ciphertext available
- out_ready  in  1  downstream accepts
- out_data  out  8  ciphertext byte, equals st register
- busy  out  1  high in ROUND or DONE

## Operation
- Registers:
  - st[7:0]: state byte.
  - rk[7:0]: round key.
  - rc[3:0]: round counter.
  - FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: st<=in_data, rk<=in_key, rc<=0, go to ROUND.
- ROUND, one round per cycle:
  - st <= rotl1(sbox_out).
  - rk <= rotl3(rk) ^ {4'h0, rc+1}, with rc+1 truncated to 4 bits.
  - rc <= rc+1.
  - When rc==ROUNDS-1, apply the same updates (plus whitening if enabled, see Configuration) and go to DONE.
- DONE:
  - out_valid=1; out_data held stable.
  - On out_ready: go to IDLE.
  - st, rk and rc keep their values until the next accept.
- in_valid outside IDLE is ignored, because in_ready=0 there. Upstream must hold its data until accepted.
- out_ready outside DONE is ignored.
- All arithmetic is 8-bit modulo. Rotations are bit rotations, not shifts.
- sbox_in always equals st^rk, including in IDLE and DONE. This keeps it deterministic; it is not meaningful outside ROUND.

## Timing
- Reset values:
  - FSM=IDLE; st=0x00, rk=0x00, rc=0.
  - in_ready=1, out_valid=0, out_data=0x00, busy=0, sbox_in=0x00.
- Latency:
  - Input accepted on the edge of cycle 0.
  - ROUND occupies cycles 1..ROUNDS.
  - out_valid is high from cycle ROUNDS+1.
- Throughput: at best one byte per ROUNDS+2 cycles. The out handshake in DONE returns to IDLE, and the next accept happens in the following cycle at the earliest.
- Backpressure: out_valid and out_data stay stable for any number of cycles until out_ready.
- Reset asserted mid-round or in DONE:
  - All registers return to their reset values immediately, without waiting for a clock.
  - An in-flight byte is dropped; no partial output.
- The S-box path is combinational within one cycle: sbox_in to sbox_out to st D-input. No pipeline register.

## Configuration
- CIPHER_FINAL_WHITEN_EN:
  - Defined: on the final ROUND cycle, st <= rotl1(sbox_out) ^ (rotl3(rk) ^ {4'h0, rc+1}), i.e. a post-whitening with the next round key.
  - Undefined: the final round is identical to the others and there is no post-whitening.
- Latency is the same either way.

## Test plan
Bench instantiates the team's 8-bit forward S-box LUT (0x00→0x63, 0x01→0x7c, 0xF9→0x99) on sbox_in/sbox_out.
- ROUNDS=1, in_data=0x00, in_key=0x00 → out_valid at cycle 2, out_data=0xC6; 0xC7 with CIPHER_FINAL_WHITEN_EN.
- ROUNDS=2, in_data=0x01, in_key=0x00:
  - round 0: sbox_in=0x01, then 0xF9 in round 1.
  - Result: out_data=0x33; 0x39 with whitening (rk=0x0A).
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_data stable; in_ready=0 throughout. A new in_valid with 0x55 is not accepted until the cycle after the out handshake.
- Reset mid-operation: assert rst_n=0 during ROUND cycle 2 of ROUNDS=4 → immediately in_ready=1, busy=0, out_valid=0, sbox_in=0x00. No out_valid follows after release.
- Back-to-back: 8 random byte/key pairs with in_valid held high and out_ready=1 → each result matches the reference model, with ROUNDS+2 cycles between successive accepts.
- ROUNDS=15 → rc reaches 14 and then DONE.
  - The round constant reaches 0x0F with no 4-bit overflow.
  - Output matches the model.
